// File: rtl/freq_monitor_pkg.sv
// Shared types and helpers for the frequency monitor: range classification
// encoding and saturating threshold arithmetic.
package freq_monitor_pkg;

    typedef enum logic [1:0] {
        NOCLK = 2'd0,
        LOW   = 2'd1,
        OK    = 2'd2,
        HIGH  = 2'd3
    } freq_state_t;

    localparam int CONF_W = 4;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/freq_monitor_avg.sv
// Boxcar averager: sample history, running sum, fill tracking and the
// registered average output, all cleared by the statistics clear strobe.
module freq_monitor_avg
    import freq_monitor_pkg::*;
#(
    parameter int AVG_LOG = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_upd,
    input  logic        i_clr,
    input  logic [31:0] i_smp,
    output logic [31:0] o_avg,
    output logic        o_avg_vld
);

    localparam int WIN   = 1 << AVG_LOG;
    localparam int SUM_W = 32 + AVG_LOG;
    localparam logic [AVG_LOG:0] FILL_MAX = (AVG_LOG + 1)'(WIN);
    localparam logic [AVG_LOG:0] FILL_ONE = (AVG_LOG + 1)'(1);

    logic [31:0]      r_hist [WIN];
    logic [SUM_W-1:0] r_sum;
    logic [AVG_LOG:0] r_fill;
    logic [31:0]      r_avg;
    logic             r_avg_vld;

    logic [SUM_W-1:0] w_sum_nxt;
    logic [AVG_LOG:0] w_fill_nxt;

    // Next running sum and saturating fill count for an incoming sample
    always_comb begin
        w_sum_nxt = r_sum + SUM_W'(i_smp) - SUM_W'(r_hist[WIN-1]);
        if (r_fill == FILL_MAX) begin
            w_fill_nxt = r_fill;
        end else begin
            w_fill_nxt = r_fill + FILL_ONE;
        end
    end

    // History, sum, fill and average registers; clear has priority over update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < WIN; i++) r_hist[i] <= 32'd0;
            r_sum     <= '0;
            r_fill    <= '0;
            r_avg     <= 32'd0;
            r_avg_vld <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < WIN; i++) r_hist[i] <= 32'd0;
            r_sum     <= '0;
            r_fill    <= '0;
            r_avg     <= 32'd0;
            r_avg_vld <= 1'b0;
        end else begin
            // average lags the sum by one cycle; empty slots count as zero
            r_avg <= r_sum[SUM_W-1:AVG_LOG];
            if (i_upd) begin
                r_hist[0] <= i_smp;
                for (int i = 1; i < WIN; i++) r_hist[i] <= r_hist[i-1];
                r_sum     <= w_sum_nxt;
                r_fill    <= w_fill_nxt;
                r_avg_vld <= (w_fill_nxt == FILL_MAX);
            end
        end
    end

    assign o_avg     = r_avg;
    assign o_avg_vld = r_avg_vld;

endmodule

// File: rtl/freq_monitor.sv
// Frequency monitor: samples the meter result once per period, tracks
// min/max/average and classifies the frequency with hysteresis and confirmation.
module freq_monitor
    import freq_monitor_pkg::*;
#(
    parameter logic [31:0] SMP_PER = 32'd15625000,
    parameter int          AVG_LOG = 3,
    parameter int          CONF    = 2,
    parameter logic [31:0] HYS     = 32'd1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] freq_i,
    input  logic [31:0] lim_lo_i,
    input  logic [31:0] lim_hi_i,
    input  logic        clr_i,
    output logic [31:0] smp_o,
    output logic [31:0] avg_o,
    output logic        avg_vld_o,
    output logic [31:0] min_o,
    output logic [31:0] max_o,
    output logic [1:0]  state_o,
    output logic        evt_o
);

    localparam logic [CONF_W-1:0] CONF_L = CONF_W'(CONF);

    logic [31:0]       r_cnt;
    logic [31:0]       r_smp;
    logic              r_stg2;
    logic [31:0]       r_min;
    logic [31:0]       r_max;
    freq_state_t       r_state;
    freq_state_t       r_cand;
    logic [CONF_W-1:0] r_conf;
    logic              r_evt;

    logic              w_tick;
    logic [31:0]       w_lo_hys;
    logic [31:0]       w_hi_hys;
    freq_state_t       w_state_nxt;
    freq_state_t       w_cand;
    freq_state_t       w_cand_nxt;
    logic              w_has_cand;
    logic [CONF_W-1:0] w_conf_cnt;
    logic [CONF_W-1:0] w_conf_nxt;

    assign w_tick   = (r_cnt >= SMP_PER);
    assign w_lo_hys = sat_add32(lim_lo_i, HYS);
    assign w_hi_hys = sat_sub32(lim_hi_i, HYS);

    // Sample period counter (1..SMP_PER), sample capture and stage-2 strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= 32'd1;
            r_smp  <= 32'd0;
            r_stg2 <= 1'b0;
        end else begin
            r_stg2 <= w_tick;
            if (w_tick) begin
                r_cnt <= 32'd1;
                r_smp <= freq_i;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Min/max tracking; a clear coinciding with stage 2 drops that sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_min <= 32'hFFFF_FFFF;
            r_max <= 32'd0;
        end else if (clr_i) begin
            r_min <= 32'hFFFF_FFFF;
            r_max <= 32'd0;
        end else if (r_stg2) begin
            if (r_smp < r_min) r_min <= r_smp;
            if (r_smp > r_max) r_max <= r_smp;
        end
    end

    // Classification next-state: candidate selection and confirmation counting
    always_comb begin
        w_state_nxt = r_state;
        w_cand      = r_state;
        w_cand_nxt  = r_cand;
        w_has_cand  = 1'b0;
        w_conf_cnt  = r_conf;
        w_conf_nxt  = r_conf;
        if (!r_stg2) begin
            w_state_nxt = r_state;
        end else if (r_smp == 32'd0) begin
            w_state_nxt = NOCLK;
            w_conf_nxt  = '0;
        end else if (r_state == NOCLK) begin
            // HIGH wins when limits are inverted, so OK is simply unreachable
            if (r_smp > lim_hi_i) begin
                w_state_nxt = HIGH;
            end else if (r_smp < lim_lo_i) begin
                w_state_nxt = LOW;
            end else begin
                w_state_nxt = OK;
            end
            w_conf_nxt = '0;
        end else begin
            case (r_state)
                OK: begin
                    if (r_smp > lim_hi_i) begin
                        w_cand = HIGH; w_has_cand = 1'b1;
                    end else if (r_smp < lim_lo_i) begin
                        w_cand = LOW;  w_has_cand = 1'b1;
                    end else begin
                        w_has_cand = 1'b0;
                    end
                end
                LOW: begin
                    if (r_smp > lim_hi_i) begin
                        w_cand = HIGH; w_has_cand = 1'b1;
                    end else if (r_smp >= w_lo_hys) begin
                        w_cand = OK;   w_has_cand = 1'b1;
                    end else begin
                        w_has_cand = 1'b0;
                    end
                end
                HIGH: begin
                    if (r_smp < lim_lo_i) begin
                        w_cand = LOW;  w_has_cand = 1'b1;
                    end else if (r_smp <= w_hi_hys) begin
                        w_cand = OK;   w_has_cand = 1'b1;
                    end else begin
                        w_has_cand = 1'b0;
                    end
                end
                default: begin
                    w_has_cand = 1'b0;
                end
            endcase
            if (!w_has_cand) begin
                w_conf_cnt = '0;
            end else if ((r_conf != '0) && (w_cand == r_cand)) begin
                w_conf_cnt = r_conf + CONF_W'(1);
            end else begin
                w_conf_cnt = CONF_W'(1);
            end
            w_cand_nxt = w_cand;
            if (w_has_cand && (w_conf_cnt >= CONF_L)) begin
                w_state_nxt = w_cand;
                w_conf_nxt  = '0;
            end else begin
                w_conf_nxt  = w_conf_cnt;
            end
        end
    end

    // Classification state register and change-event pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= NOCLK;
            r_cand  <= NOCLK;
            r_conf  <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_conf  <= w_conf_nxt;
            r_evt   <= (w_state_nxt != r_state);
        end
    end

    freq_monitor_avg #(
        .AVG_LOG (AVG_LOG)
    ) u_avg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_upd     (r_stg2),
        .i_clr     (clr_i),
        .i_smp     (r_smp),
        .o_avg     (avg_o),
        .o_avg_vld (avg_vld_o)
    );

    assign smp_o   = r_smp;
    assign min_o   = r_min;
    assign max_o   = r_max;
    assign state_o = r_state;
    assign evt_o   = r_evt;

endmodule

// File: tb/tb_freq_monitor.sv
// Self-checking bench for freq_monitor: directed vector table followed by
// randomized samples, both checked against a behavioural reference model.
module tb_freq_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] freq_i, lim_lo_i, lim_hi_i;
    logic        clr_i;
    logic [31:0] smp_o, avg_o, min_o, max_o;
    logic        avg_vld_o, evt_o;
    logic [1:0]  state_o;

    freq_monitor #(
        .SMP_PER (32'd4),
        .AVG_LOG (2),
        .CONF    (2),
        .HYS     (32'd10)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .freq_i    (freq_i),
        .lim_lo_i  (lim_lo_i),
        .lim_hi_i  (lim_hi_i),
        .clr_i     (clr_i),
        .smp_o     (smp_o),
        .avg_o     (avg_o),
        .avg_vld_o (avg_vld_o),
        .min_o     (min_o),
        .max_o     (max_o),
        .state_o   (state_o),
        .evt_o     (evt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model: window of the last four samples, stats, classifier
    longint unsigned m_win[$];
    int              m_fill;
    longint unsigned m_min, m_max, m_smp, pend;
    int              m_st, m_pcand, m_cnt;
    bit              m_evt, has_pend;

    typedef struct {
        logic [31:0] f;
        int          clr;
        logic [31:0] lo;
        logic [31:0] hi;
        int          exp_st;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic m_clear();
        m_win = {64'd0, 64'd0, 64'd0, 64'd0};
        m_fill = 0;
        m_min = 64'hFFFF_FFFF;
        m_max = 64'd0;
    endtask

    task automatic m_reset();
        m_clear();
        m_st = 0; m_pcand = -1; m_cnt = 0; m_evt = 1'b0;
        m_smp = 64'd0; has_pend = 1'b0;
    endtask

    function automatic longint unsigned m_avg();
        longint unsigned s = 64'd0;
        foreach (m_win[i]) s += m_win[i];
        return s / 64'd4;
    endfunction

    task automatic m_stats(input longint unsigned s);
        m_win.push_back(s);
        void'(m_win.pop_front());
        if (m_fill < 4) m_fill++;
        if (s < m_min) m_min = s;
        if (s > m_max) m_max = s;
    endtask

    // states: 0 NOCLK, 1 LOW, 2 OK, 3 HIGH; cand -1 = none
    task automatic m_classify(input longint unsigned s);
        longint unsigned lo = lim_lo_i;
        longint unsigned hi = lim_hi_i;
        longint unsigned lo_h = (lo + 64'd10 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : lo + 64'd10;
        longint unsigned hi_h = (hi >= 64'd10) ? hi - 64'd10 : 64'd0;
        int nst = m_st;
        int cand = -1;
        if (s == 0) begin
            nst = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            nst = (s > hi) ? 3 : (s < lo) ? 1 : 2;
            m_cnt = 0;
        end else begin
            if (m_st == 2)      cand = (s > hi) ? 3 : (s < lo) ? 1 : -1;
            else if (m_st == 1) cand = (s > hi) ? 3 : (s >= lo_h && s <= hi) ? 2 : -1;
            else                cand = (s < lo) ? 1 : (s <= hi_h && s >= lo) ? 2 : -1;
            if (cand < 0) m_cnt = 0;
            else if (m_cnt > 0 && cand == m_pcand) m_cnt++;
            else m_cnt = 1;
            m_pcand = cand;
            if (m_cnt >= 2) begin
                nst = cand; m_cnt = 0;
            end
        end
        m_evt = (nst != m_st);
        m_st = nst;
    endtask

    // One sample period. clr_mode 1: clear on the stage-2 cycle of the pending
    // sample; 2: clear one cycle after that stage 2. New limits apply to f.
    task automatic sample(input logic [31:0] f, input int clr_mode,
                          input logic [31:0] lo_n, input logic [31:0] hi_n);
        freq_i = f;
        clr_i  = (clr_mode == 1);
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        m_evt = 1'b0;
        if (has_pend) m_classify(pend);
        if (clr_mode == 1) m_clear();
        else if (has_pend) m_stats(pend);
        chk("state", state_o, m_st);
        chk("evt_pulse", evt_o, m_evt);
        if (clr_mode == 2) clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        if (clr_mode == 2) m_clear();
        chk("evt_end", evt_o, 0);
        chk("avg", avg_o, m_avg());
        chk("avg_vld", avg_vld_o, (m_fill == 4));
        chk("min", min_o, m_min);
        chk("max", max_o, m_max);
        chk("smp_hold", smp_o, m_smp);
        repeat (2) @(posedge clk_i);
        #1;
        chk("smp", smp_o, f);
        m_smp = f; pend = f; has_pend = 1'b1;
        lim_lo_i = lo_n; lim_hi_i = hi_n;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_smp"}, smp_o, 0);
        chk({tag, "_avg"}, avg_o, 0);
        chk({tag, "_vld"}, avg_vld_o, 0);
        chk({tag, "_min"}, min_o, 64'hFFFF_FFFF);
        chk({tag, "_max"}, max_o, 0);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_evt"}, evt_o, 0);
    endtask

    task automatic add(input logic [31:0] f, input int c, input logic [31:0] lo,
                       input logic [31:0] hi, input int st);
        vec_t v;
        v.f = f; v.clr = c; v.lo = lo; v.hi = hi; v.exp_st = st;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] lo_r, hi_r, f_r;
        int          c_r;
        rst_i = 1'b1; freq_i = 32'd0; clr_i = 1'b0;
        lim_lo_i = 32'd100; lim_hi_i = 32'd200;
        #12;
        check_reset_vals("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_reset();

        // directed sequence: {freq, clr, lim_lo, lim_hi, expected state after it}
        add(32'd0,   0, 32'd100, 32'd200, 0);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd95,  0, 32'd100, 32'd200, 2);
        add(32'd150, 0, 32'd100, 32'd200, 2);
        add(32'd95,  0, 32'd100, 32'd200, 2);
        add(32'd95,  0, 32'd100, 32'd200, 1);
        add(32'd105, 0, 32'd100, 32'd200, 1);
        add(32'd115, 0, 32'd100, 32'd200, 1);
        add(32'd115, 0, 32'd100, 32'd200, 2);
        add(32'd250, 0, 32'd100, 32'd200, 2);
        add(32'd0,   0, 32'd100, 32'd200, 0);
        add(32'd250, 0, 32'd100, 32'd200, 3);
        add(32'd10,  0, 32'd100, 32'd200, 3);
        add(32'd20,  0, 32'd100, 32'd200, 1);
        add(32'd30,  0, 32'd100, 32'd200, 1);
        add(32'd40,  0, 32'd100, 32'd200, 1);
        add(32'd150, 0, 32'd100, 32'd200, 1);
        add(32'd150, 2, 32'd100, 32'd200, 2);
        add(32'd150, 1, 32'd100, 32'd200, 2);
        add(32'd180, 0, 32'd100, 32'd200, 2);
        add(32'd0,   0, 32'd100, 32'd200, 0);
        add(32'd1,   0, 32'd10,  32'd5,   1);
        add(32'd7,   0, 32'd10,  32'd5,   1);
        add(32'd7,   0, 32'd10,  32'd5,   3);
        add(32'd7,   0, 32'd10,  32'd5,   3);
        add(32'd7,   0, 32'd10,  32'd5,   1);
        add(32'd0,   0, 32'd100, 32'd200, 0);
        add(32'd0,   0, 32'd100, 32'd200, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            sample(tbl[i].f, tbl[i].clr, tbl[i].lo, tbl[i].hi);
            if (i > 0) chk("tbl_state", state_o, tbl[i-1].exp_st);
        end

        // asynchronous reset in the middle of a period
        sample(32'd150, 0, 32'd100, 32'd200);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_reset();

        // randomized samples around the current thresholds
        lo_r = 32'd100; hi_r = 32'd200;
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin lo_r = 32'd100;         hi_r = 32'd200;         end
                    1: begin lo_r = 32'd10;          hi_r = 32'd5;           end
                    2: begin lo_r = 32'hFFFF_FFF8;   hi_r = 32'hFFFF_FFFF;   end
                    default: begin lo_r = 32'd0;     hi_r = 32'd8;           end
                endcase
            end
            case ($urandom_range(0, 9))
                0: f_r = 32'd0;
                1: f_r = lo_r - 32'd1;
                2: f_r = lo_r;
                3: f_r = lo_r + 32'd9;
                4: f_r = lo_r + 32'd10;
                5: f_r = hi_r;
                6: f_r = hi_r + 32'd1;
                7: f_r = hi_r - 32'd10;
                8: f_r = hi_r - 32'd11;
                default: f_r = $urandom_range(0, 300);
            endcase
            c_r = $urandom_range(0, 11);
            c_r = (c_r == 0) ? 1 : (c_r == 1) ? 2 : 0;
            sample(f_r, c_r, lo_r, hi_r);
        end
        sample(32'd0, 0, 32'd100, 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
